gesture_bbox_detector: RTL
==========================

GESTURE_BBOX_DETECTOR -- requirements
Module: gesture_bbox_detector

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter MIN_PIXELS, default 64, meaning the minimum foreground count for a valid hand region.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port per_frame_vsync, input, 1 bit: frame valid, high for the whole frame.
REQ-007 SHALL have port per_frame_href, input, 1 bit: line valid.
REQ-008 SHALL have port per_frame_clken, input, 1 bit: pixel enable.
REQ-009 SHALL have port per_img_bit, input, 1 bit: dilated binary pixel, 1 = foreground.
REQ-010 SHALL have ports bbox_left, bbox_right, bbox_top, bbox_bottom, output, 11 bits each: registered box bounds (inclusive).
REQ-011 SHALL have port pixel_count, output, 20 bits: foreground pixels in the last frame.
REQ-012 SHALL have port bbox_found, output, 1 bit: high when pixel_count >= MIN_PIXELS.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the results update.

Function
REQ-014 Counter x SHALL increment on each clk where vsync&href&clken is 1, saturating at IMG_WIDTH.
REQ-015 Counter x SHALL clear on the cycle after href is sampled falling.
REQ-016 Counter y SHALL increment on each href falling edge, saturating at IMG_HEIGHT, and clear when the FSM enters ACTIVE.
REQ-017 A pixel SHALL be accumulated only when vsync&href&clken&per_img_bit is 1, x < IMG_WIDTH and y < IMG_HEIGHT.
REQ-018 The coordinate used for an accumulated pixel SHALL be the value of x/y before that cycle's increment.
REQ-019 Accumulation SHALL perform cnt+=1 (saturating at 2^20-1), min_x=min(min_x,x), max_x=max(max_x,x), min_y=min(min_y,y) and max_y=max(max_y,y).
REQ-020 Accumulators SHALL initialise on ACTIVE entry to min=2047, max=0 and cnt=0.
REQ-021 The FSM SHALL have states IDLE, ACTIVE and LATCH.
REQ-022 The FSM SHALL move IDLE->ACTIVE on a vsync rising edge (vsync=1, registered vsync_d=0).
REQ-023 The FSM SHALL move ACTIVE->LATCH on a vsync falling edge (vsync=0, vsync_d=1).
REQ-024 The FSM SHALL move LATCH->IDLE unconditionally after one cycle.
REQ-025 A vsync rising edge in LATCH SHALL be taken on the cycle after LATCH (IDLE->ACTIVE) and SHALL NOT be lost.
REQ-026 On the LATCH cycle, the outputs SHALL register: pixel_count=cnt and bbox_found=(cnt>=MIN_PIXELS).
REQ-027 If the region is found, the bbox outputs SHALL take the accumulator min/max values.
REQ-028 If the region is not found, all four bbox outputs SHALL be 0.
REQ-029 frame_done SHALL be 1 for exactly the cycle after LATCH, i.e. 2 cycles after vsync is first sampled low.
REQ-030 The outputs SHALL hold their values until the next LATCH.
REQ-031 Inputs while in IDLE SHALL be ignored, so a frame already in progress at reset release is discarded.
REQ-032 An href falling edge coincident with a vsync falling edge SHALL still count the final pixel; y is not used afterwards.

Reset
REQ-033 On rst_n=0 the FSM SHALL enter IDLE and x, y, cnt, vsync_d and href_d SHALL be 0.
REQ-034 On rst_n=0 all outputs SHALL be 0, including frame_done and bbox_found.
REQ-035 The accumulator min registers SHALL be 2047 on reset.
REQ-036 An assertion of rst_n mid-frame SHALL abort the frame with no frame_done.

Verification
REQ-037 The bench SHALL cover this scenario: a 640x480 frame with foreground at x 100..199, y 50..149 -> frame_done one pulse, bbox 100/199/50/149, pixel_count 10000, bbox_found 1.
REQ-038 The bench SHALL cover this scenario: an all-zero frame -> pixel_count 0, bbox_found 0, bbox all 0, one frame_done pulse.
REQ-039 The bench SHALL cover this scenario: 63 isolated foreground pixels -> bbox_found 0 and pixel_count 63; then 64 pixels -> bbox_found 1.
REQ-040 The bench SHALL cover this scenario: a single pixel at (639,479) and a second at (0,0) -> bbox 0/639/0/479, count 2 with MIN_PIXELS=1.
REQ-041 The bench SHALL cover this scenario: rst_n pulsed mid-frame, then vsync still high at release -> no frame_done until the next full frame, whose results are correct.
REQ-042 The bench SHALL cover this scenario: clken gapped (1 of 2 cycles) and back-to-back frames with 1-cycle vsync low -> identical results to ungapped, with both frames reported.

Source files
------------

// File: rtl/gesture_bbox_detector.sv
`default_nettype none
// ============================================================================
// gesture_bbox_detector : per-frame bounding box and foreground count of a binary hand mask
// Revision 1.0
// ============================================================================
module gesture_bbox_detector #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_bit,
  output logic [10:0] bbox_left,
  output logic [10:0] bbox_right,
  output logic [10:0] bbox_top,
  output logic [10:0] bbox_bottom,
  output logic [19:0] pixel_count,
  output logic        bbox_found,
  output logic        frame_done
);

  localparam logic [10:0] c_w        = 11'(IMG_WIDTH);
  localparam logic [10:0] c_h        = 11'(IMG_HEIGHT);
  localparam logic [19:0] c_min_pix  = 20'(MIN_PIXELS);
  localparam logic [10:0] c_min_init = 11'd2047;
  localparam logic [19:0] c_cnt_max  = 20'hF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    LATCH  = 2'd2
  } state_t;

  state_t      state_q;
  logic        vsync_q;
  logic        href_q;
  logic        armed_q;
  logic        pend_q;
  logic [10:0] x_q;
  logic [10:0] y_q;
  logic [10:0] min_x_q;
  logic [10:0] max_x_q;
  logic [10:0] min_y_q;
  logic [10:0] max_y_q;
  logic [19:0] cnt_q;

  logic w_vs_rise;
  logic w_vs_fall;
  logic w_href_fall;
  logic w_pix_en;
  logic w_accum;
  logic w_enter_active;
  logic w_found;

  // A rising edge only counts once vsync has been seen low since reset, so a
  // frame already running when reset is released never starts a capture.
  assign w_vs_rise      = per_frame_vsync & ~vsync_q & armed_q;
  assign w_vs_fall      = ~per_frame_vsync & vsync_q;
  assign w_href_fall    = ~per_frame_href & href_q;
  assign w_pix_en       = per_frame_vsync & per_frame_href & per_frame_clken;
  assign w_accum        = (state_q == ACTIVE) & w_pix_en & per_img_bit &
                          (x_q < c_w) & (y_q < c_h);
  assign w_enter_active = (state_q == IDLE) & (w_vs_rise | pend_q);
  assign w_found        = (cnt_q >= c_min_pix);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      armed_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      min_x_q <= c_min_init;
      min_y_q <= c_min_init;
      max_x_q <= '0;
      max_y_q <= '0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      armed_q <= armed_q | ~per_frame_vsync;

      if (w_href_fall) begin
        x_q <= '0;
      end else if (w_pix_en && (x_q != c_w)) begin
        x_q <= x_q + 11'd1;
      end

      if (w_enter_active) begin
        y_q <= '0;
      end else if (w_href_fall && (y_q != c_h)) begin
        y_q <= y_q + 11'd1;
      end

      if (w_enter_active) begin
        cnt_q   <= '0;
        min_x_q <= c_min_init;
        min_y_q <= c_min_init;
        max_x_q <= '0;
        max_y_q <= '0;
      end else if (w_accum) begin
        if (cnt_q != c_cnt_max) cnt_q <= cnt_q + 20'd1;
        if (x_q < min_x_q) min_x_q <= x_q;
        if (x_q > max_x_q) max_x_q <= x_q;
        if (y_q < min_y_q) min_y_q <= y_q;
        if (y_q > max_y_q) max_y_q <= y_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      frame_done  <= 1'b0;
      bbox_found  <= 1'b0;
      pixel_count <= '0;
      bbox_left   <= '0;
      bbox_right  <= '0;
      bbox_top    <= '0;
      bbox_bottom <= '0;
    end else begin
      frame_done <= 1'b0;
      // A new frame starting during LATCH is remembered for the following IDLE cycle.
      pend_q     <= (state_q == LATCH) & w_vs_rise;
      case (state_q)
        IDLE: begin
          if (w_enter_active) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (w_vs_fall) state_q <= LATCH;
        end
        LATCH: begin
          state_q     <= IDLE;
          frame_done  <= 1'b1;
          pixel_count <= cnt_q;
          bbox_found  <= w_found;
          bbox_left   <= w_found ? min_x_q : 11'd0;
          bbox_right  <= w_found ? max_x_q : 11'd0;
          bbox_top    <= w_found ? min_y_q : 11'd0;
          bbox_bottom <= w_found ? max_y_q : 11'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
